// File: rtl/bytecode_stream_decoder.sv
// Fetches FETCH_BYTES-wide words into a circular byte queue and splits them into
// variable-length JVM instructions (opcode + 0..2 operand bytes), one per handshake.
module bytecode_stream_decoder #(
    parameter int BYTE        = 8,
    parameter int FETCH_BYTES = 4,
    parameter int BUF_BYTES   = 8,
    parameter int ADDR_W      = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           start_pc,
    output logic                        ready,
    output logic                        mem_req,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic                        mem_ack,
    input  logic [FETCH_BYTES*BYTE-1:0] mem_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BYTE-1:0]             opcode,
    output logic [2*BYTE-1:0]           operand,
    output logic [1:0]                  op_len,
    output logic [ADDR_W-1:0]           pc_out,
    output logic                        illegal
);
    localparam int PTR_W = $clog2(BUF_BYTES);
    localparam int CNT_W = PTR_W + 1;
    localparam int OFF_W = $clog2(FETCH_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t            state, state_nx;
    logic [BYTE-1:0]   q [BUF_BYTES];
    logic [PTR_W-1:0]  head;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] pc;
    logic [OFF_W-1:0]  drop;
    logic              first_word;
    logic              discard;

    // Returns {illegal, len}; unsupported opcodes decode as length 1.
    function automatic logic [2:0] decode_len(input logic [BYTE-1:0] b);
        int unsigned v;
        v = 32'(b);
        if (v inside {32'h10, 32'h12, [32'h15:32'h19], [32'h36:32'h3A], 32'hA9, 32'hBC})
            return 3'b0_10;
        else if (v inside {32'h11, 32'h13, 32'h14, 32'h84, [32'h99:32'hA8], [32'hB2:32'hB8],
                           32'hBB, 32'hBD, 32'hC0, 32'hC1, 32'hC6, 32'hC7})
            return 3'b0_11;
        else if (v inside {32'hAA, 32'hAB, 32'hB9, 32'hBA, 32'hC4, 32'hC5} || v >= 32'hC8)
            return 3'b1_01;
        else
            return 3'b0_01;
    endfunction

    logic              start_go, accept, halting, ack, take;
    logic [1:0]        pop_len;
    logic [PTR_W-1:0]  nhead, tail;
    logic [CNT_W-1:0]  ncnt, push_n;
    logic [OFF_W-1:0]  drop_eff;
    logic [BYTE-1:0]   b0, b1, b2;
    logic [2:0]        dec;

    assign ready    = (state != S_RUN);
    assign start_go = start && ready;
    assign accept   = out_valid && out_ready;
    assign halting  = accept && illegal;
    assign ack      = mem_ack && mem_req;
    // A word requested before the halt is absorbed without touching the queue.
    assign take     = ack && !discard;
    assign pop_len  = accept ? op_len : 2'd0;
    assign drop_eff = first_word ? drop : '0;
    assign push_n   = take ? (CNT_W'(FETCH_BYTES) - CNT_W'(drop_eff)) : '0;
    assign tail     = head + count[PTR_W-1:0];

    // Next instruction is decoded from the post-pop queue so accepts can run back-to-back.
    assign nhead = head + PTR_W'(pop_len);
    assign ncnt  = count - CNT_W'(pop_len);
    assign b0    = q[nhead];
    assign b1    = q[nhead + PTR_W'(1)];
    assign b2    = q[nhead + PTR_W'(2)];
    assign dec   = decode_len(b0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (halting) state_nx = S_HALT;
            S_HALT:  if (start) state_nx = S_RUN;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (take) begin
            for (int i = 0; i < FETCH_BYTES; i++) begin
                if (OFF_W'(i) >= drop_eff)
                    q[tail + PTR_W'(i) - PTR_W'(drop_eff)] <= mem_data[(FETCH_BYTES-1-i)*BYTE +: BYTE];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head       <= '0;
            count      <= '0;
            fetch_addr <= '0;
            pc         <= '0;
            drop       <= '0;
            first_word <= 1'b0;
            discard    <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            out_valid  <= 1'b0;
            opcode     <= '0;
            operand    <= '0;
            op_len     <= '0;
            pc_out     <= '0;
            illegal    <= 1'b0;
        end else begin
            if (start_go) begin
                head       <= '0;
                count      <= '0;
                fetch_addr <= start_pc & ~ADDR_W'(FETCH_BYTES-1);
                drop       <= start_pc[OFF_W-1:0];
                first_word <= 1'b1;
                pc         <= start_pc;
            end else begin
                head  <= nhead;
                count <= ncnt + push_n;
                if (take) begin
                    fetch_addr <= fetch_addr + ADDR_W'(FETCH_BYTES);
                    first_word <= 1'b0;
                end
                if (accept) pc <= pc + ADDR_W'(op_len);
            end

            // Only one outstanding request, issued when a whole word is guaranteed to fit.
            if (ack) begin
                mem_req <= 1'b0;
            end else if (!mem_req && state == S_RUN && !halting &&
                         count <= CNT_W'(BUF_BYTES - FETCH_BYTES)) begin
                mem_req  <= 1'b1;
                mem_addr <= fetch_addr;
            end

            if (halting && mem_req && !mem_ack) discard <= 1'b1;
            else if (ack)                       discard <= 1'b0;

            if (!out_valid || accept) begin
                if (state == S_RUN && !halting && ncnt >= CNT_W'(dec[1:0])) begin
                    out_valid <= 1'b1;
                    opcode    <= b0;
                    op_len    <= dec[1:0];
                    illegal   <= dec[2];
                    pc_out    <= pc + ADDR_W'(pop_len);
                    case (dec[1:0])
                        2'd2:    operand <= {{BYTE{1'b0}}, b1};
                        2'd3:    operand <= {b1, b2};
                        default: operand <= '0;
                    endcase
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_bytecode_stream_decoder.sv
// Directed bench: memory responder, scoreboard of expected instructions, monitor on accepts.
module tb_bytecode_stream_decoder;
    logic        clk, reset, start, ready, mem_req, mem_ack, out_valid, out_ready, illegal;
    logic [15:0] start_pc, mem_addr, operand, pc_out;
    logic [31:0] mem_data;
    logic [7:0]  opcode;
    logic [1:0]  op_len;

    bytecode_stream_decoder dut (
        .clk(clk), .reset(reset), .start(start), .start_pc(start_pc), .ready(ready),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode), .operand(operand),
        .op_len(op_len), .pc_out(pc_out), .illegal(illegal)
    );

    typedef struct packed {
        logic [7:0]  opc;
        logic [15:0] opd;
        logic [1:0]  len;
        logic [15:0] pc;
        logic        ill;
    } ins_t;

    ins_t        sb[$];
    logic [15:0] flog[$];
    logic [31:0] mem [16];
    int          checks = 0, errors = 0, ack_delay = 0, wait_cnt = 0;

    initial begin clk = 0; forever #5 clk = ~clk; end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic expect_ins(input logic [7:0] opc, input logic [15:0] opd,
                              input logic [1:0] len, input logic [15:0] pc, input logic ill);
        sb.push_back('{opc, opd, len, pc, ill});
    endtask

    task automatic do_start(input logic [15:0] pc);
        start_pc = pc; start = 1; tick(); start = 0;
    endtask

    task automatic wait_halt(input string tag);
        logic done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            tick();
            done = ready && !mem_req && sb.size() == 0;
        end
        chk(tag, 64'(done), 64'd1);
    endtask

    // Memory responder: acks after ack_delay cycles of a pending request.
    initial begin
        mem_ack = 0; mem_data = '0;
        forever begin
            @(posedge clk); #1;
            if (!reset) begin
                mem_ack = 0; wait_cnt = 0;
            end else if (mem_ack) begin
                mem_ack = 0;
            end else if (mem_req) begin
                if (wait_cnt >= ack_delay) begin
                    mem_ack = 1; mem_data = mem[mem_addr[5:2]];
                    flog.push_back(mem_addr); wait_cnt = 0;
                end else wait_cnt++;
            end
        end
    end

    // Monitor: every accepted instruction must match the scoreboard head.
    initial begin
        ins_t e;
        forever begin
            @(negedge clk);
            if (reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $error("FAIL unexpected_instr observed op %0h pc %0h expected none", opcode, pc_out);
                end else begin
                    e = sb.pop_front();
                    chk("instr", 64'({opcode, operand, op_len, pc_out, illegal}), 64'(e));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        int   n;
        reset = 0; start = 0; start_pc = 0; out_ready = 0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        #12;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_outs", 64'({out_valid, mem_req, mem_addr, opcode, operand, op_len, pc_out, illegal}), 64'd0);
        tick(); reset = 1; tick();

        // 1: basic split plus latency
        mem[0] = 32'h0304107F; mem[1] = 32'hFF000000;
        expect_ins(8'h03, 16'h0000, 2'd1, 16'd0, 1'b0);
        expect_ins(8'h04, 16'h0000, 2'd1, 16'd1, 1'b0);
        expect_ins(8'h10, 16'h007F, 2'd2, 16'd2, 1'b0);
        expect_ins(8'hFF, 16'h0000, 2'd1, 16'd4, 1'b1);
        out_ready = 1; start_pc = 0; start = 1;
        tick(); start = 0;
        chk("lat_req_edge0", 64'(mem_req), 64'd0);
        chk("ready_run", 64'(ready), 64'd0);
        tick();
        chk("lat_req_edge1", 64'(mem_req), 64'd1);
        chk("mem_addr0", 64'(mem_addr), 64'd0);
        tick();
        chk("lat_valid_ack_edge", 64'(out_valid), 64'd0);
        tick();
        chk("lat_valid_next", 64'(out_valid), 64'd1);
        wait_halt("t1_drain");

        // 2: operands straddling a word boundary
        mem[0] = 32'h00000011; mem[1] = 32'h12340400; mem[2] = 32'hFF000000;
        for (int i = 0; i < 3; i++) expect_ins(8'h00, 16'h0, 2'd1, 16'(i), 1'b0);
        expect_ins(8'h11, 16'h1234, 2'd3, 16'd3, 1'b0);
        expect_ins(8'h04, 16'h0000, 2'd1, 16'd6, 1'b0);
        expect_ins(8'h00, 16'h0000, 2'd1, 16'd7, 1'b0);
        expect_ins(8'hFF, 16'h0000, 2'd1, 16'd8, 1'b1);
        do_start(0);
        wait_halt("t2_drain");

        // 3: backpressure freezes outputs and fills the queue to its limit
        mem[0] = 32'h01020304; mem[1] = 32'h05060708; mem[2] = 32'hFF000000;
        out_ready = 0; flog.delete();
        do_start(0);
        repeat (4) tick();
        chk("bp_frozen_early", 64'({out_valid, opcode, op_len, pc_out}), 64'({1'b1, 8'h01, 2'd1, 16'd0}));
        repeat (8) tick();
        chk("bp_frozen_late", 64'({out_valid, opcode, op_len, pc_out}), 64'({1'b1, 8'h01, 2'd1, 16'd0}));
        chk("bp_fetch_stop", 64'(mem_req), 64'd0);
        chk("bp_fetch_count", 64'(flog.size()), 64'd2);
        for (int i = 1; i <= 8; i++) expect_ins(8'(i), 16'h0, 2'd1, 16'(i-1), 1'b0);
        expect_ins(8'hFF, 16'h0000, 2'd1, 16'd8, 1'b1);
        out_ready = 1;
        wait_halt("t3_drain");

        // 4: illegal halts with a request in flight
        ack_delay = 3;
        mem[0] = 32'h03BA0404; mem[1] = 32'h00000000;
        expect_ins(8'h03, 16'h0000, 2'd1, 16'd0, 1'b0);
        expect_ins(8'hBA, 16'h0000, 2'd1, 16'd1, 1'b1);
        do_start(0);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin tick(); found = ready; end
        chk("halt_reached", 64'(found), 64'd1);
        repeat (8) tick();
        chk("halt_no_req", 64'(mem_req), 64'd0);
        n = flog.size();
        repeat (10) tick();
        chk("halt_no_fetch", 64'(flog.size()), 64'(n));
        chk("halt_ready", 64'({ready, out_valid}), 64'b10);
        chk("halt_sb_empty", 64'(sb.size()), 64'd0);

        // 5: unaligned start drops leading bytes
        ack_delay = 1;
        mem[0] = 32'hAAAA6F91; mem[1] = 32'hFF000000;
        flog.delete();
        expect_ins(8'h6F, 16'h0000, 2'd1, 16'd2, 1'b0);
        expect_ins(8'h91, 16'h0000, 2'd1, 16'd3, 1'b0);
        expect_ins(8'hFF, 16'h0000, 2'd1, 16'd4, 1'b1);
        do_start(2);
        wait_halt("t5_drain");
        chk("t5_fetches", 64'(flog.size() >= 2), 64'd1);
        if (flog.size() >= 2) begin
            chk("t5_addr0", 64'(flog[0]), 64'd0);
            chk("t5_addr1", 64'(flog[1]), 64'd4);
        end

        // 6: reset in the middle of operation
        ack_delay = 3; out_ready = 0;
        mem[0] = 32'h0; mem[1] = 32'h0;
        do_start(0);
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin tick(); found = out_valid && mem_req; end
        chk("mid_busy", 64'(found), 64'd1);
        reset = 0; #1;
        chk("mid_rst_ready", 64'(ready), 64'd1);
        chk("mid_rst_outs", 64'({out_valid, mem_req, mem_addr, opcode, operand, op_len, pc_out, illegal}), 64'd0);
        tick(); reset = 1; tick();
        ack_delay = 0;
        mem[0] = 32'h0304107F; mem[1] = 32'hFF000000;
        expect_ins(8'h03, 16'h0000, 2'd1, 16'd0, 1'b0);
        expect_ins(8'h04, 16'h0000, 2'd1, 16'd1, 1'b0);
        expect_ins(8'h10, 16'h007F, 2'd2, 16'd2, 1'b0);
        expect_ins(8'hFF, 16'h0000, 2'd1, 16'd4, 1'b1);
        out_ready = 1;
        do_start(0);
        wait_halt("t6_restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
